// File: rtl/rx_cmd_pkg.sv
// Shared definitions for the RX command sequencer: FSM state encoding,
// command type codes, opcode bit patterns, per-command frame lengths and
// CRC5 constants (x^5+x^3+1, preset 01001).
package rx_cmd_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 7;
  localparam int unsigned TYPE_W = 3;
  localparam int unsigned CRC_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_OPCODE   = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_DONE     = 3'd4,
    ST_DISCARD  = 3'd5
  } state_t;

  typedef enum logic [TYPE_W-1:0] {
    CMD_QUERYREP = 3'd0,
    CMD_ACK      = 3'd1,
    CMD_QUERY    = 3'd2,
    CMD_QUERYADJ = 3'd3,
    CMD_NAK      = 3'd4,
    CMD_REQRN    = 3'd5,
    CMD_READ     = 3'd6
  } cmd_type_t;

  // Opcode patterns, first received bit is the MSB
  localparam logic [1:0] OP_QUERYREP = 2'b00;
  localparam logic [1:0] OP_ACK      = 2'b01;
  localparam logic [3:0] OP_QUERY    = 4'b1000;
  localparam logic [3:0] OP_QUERYADJ = 4'b1001;
  localparam logic [7:0] OP_NAK      = 8'b1100_0000;
  localparam logic [7:0] OP_REQRN    = 8'b1100_0001;
  localparam logic [7:0] OP_READ     = 8'b1100_0010;

  // Total frame length in bits, opcode included
  localparam logic [CNT_W-1:0] LEN_QUERYREP = CNT_W'(4);
  localparam logic [CNT_W-1:0] LEN_ACK      = CNT_W'(18);
  localparam logic [CNT_W-1:0] LEN_QUERY    = CNT_W'(22);
  localparam logic [CNT_W-1:0] LEN_QUERYADJ = CNT_W'(9);
  localparam logic [CNT_W-1:0] LEN_NAK      = CNT_W'(8);
  localparam logic [CNT_W-1:0] LEN_REQRN    = CNT_W'(40);
  localparam logic [CNT_W-1:0] LEN_READ     = CNT_W'(58);

  localparam logic [CRC_W-1:0] CRC5_POLY   = 5'b01001;
  localparam logic [CRC_W-1:0] CRC5_PRESET = 5'b01001;

  // Expected total length for a resolved command
  function automatic logic [CNT_W-1:0] cmd_length(input cmd_type_t t);
    logic [CNT_W-1:0] len;
    case (t)
      CMD_QUERYREP: len = LEN_QUERYREP;
      CMD_ACK:      len = LEN_ACK;
      CMD_QUERY:    len = LEN_QUERY;
      CMD_QUERYADJ: len = LEN_QUERYADJ;
      CMD_NAK:      len = LEN_NAK;
      CMD_REQRN:    len = LEN_REQRN;
      CMD_READ:     len = LEN_READ;
      default:      len = '0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/rx_cmd_sequencer_if.sv
// Bit-stream input and command output bundle of the RX command sequencer.
//   bitin/bitclk/rx_overflow : from the RX front end
//   cmd_ack                  : from the command consumer
//   cmd_valid/type/data/len  : held command to the consumer
//   cmd_err/busy             : status
// master = front end + consumer side, slave = sequencer.
interface rx_cmd_sequencer_if;
  import rx_cmd_pkg::*;

  logic              bitin;
  logic              bitclk;
  logic              rx_overflow;
  logic              cmd_ack;
  logic              cmd_valid;
  logic [TYPE_W-1:0] cmd_type;
  logic [DATA_W-1:0] cmd_data;
  logic [CNT_W-1:0]  cmd_len;
  logic              cmd_err;
  logic              busy;

  modport master (
    output bitin, bitclk, rx_overflow, cmd_ack,
    input  cmd_valid, cmd_type, cmd_data, cmd_len, cmd_err, busy
  );

  modport slave (
    input  bitin, bitclk, rx_overflow, cmd_ack,
    output cmd_valid, cmd_type, cmd_data, cmd_len, cmd_err, busy
  );
endinterface

// File: rtl/crc5_serial.sv
// Serial CRC5 (x^5+x^3+1) register. clear presets the register; when clear
// and shift coincide the shifted bit is the first bit after the preset.
//   clk, reset : clock, async active-high reset
//   clear      : restart at preset
//   shift, din : advance one bit
//   residue    : current register contents (zero after a good frame+CRC)
module crc5_serial
  import rx_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [CRC_W-1:0] residue
);

  logic [CRC_W-1:0] r_crc;
  logic [CRC_W-1:0] w_base;
  logic [CRC_W-1:0] w_next;
  logic             w_fb;

  // One LFSR step from either the preset or the running value
  always_comb begin
    w_base = clear ? CRC5_PRESET : r_crc;
    w_fb   = din ^ w_base[CRC_W-1];
    w_next = {w_base[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC5_POLY : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_crc <= CRC5_PRESET;
    else if (shift) r_crc <= w_next;
    else if (clear) r_crc <= CRC5_PRESET;
  end

  assign residue = r_crc;

endmodule

// File: rtl/rx_cmd_sequencer.sv
// RX command sequencer: shifts demodulated bits on each bitclk rising edge,
// resolves the opcode, checks frame length and holds the complete command
// until the consumer acknowledges it. Aborted frames pulse cmd_err.
//   clk, reset : clock, async active-high reset
//   bus        : rx_cmd_sequencer_if.slave (bit input, command output, status)
// Build option: RX_CMD_CRC5_EN adds a CRC5 residue check on QUERY frames.
module rx_cmd_sequencer
  import rx_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  rx_cmd_sequencer_if.slave bus
);

  state_t            r_state, w_next_state;
  logic              r_bitclk_d;
  logic [DATA_W-1:0] r_data, w_data_nxt, w_shift_data;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_shift_cnt;
  cmd_type_t         r_type, w_type_nxt;
  logic              r_valid, r_err, r_busy;
  logic              w_err, w_edge, w_crc_bad;

  assign w_edge       = bus.bitclk & ~r_bitclk_d;
  assign w_shift_data = {r_data[DATA_W-2:0], bus.bitin};
  // Saturating bit count
  assign w_shift_cnt  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef RX_CMD_CRC5_EN
  logic [CRC_W-1:0] w_residue;
  logic             w_crc_clear;
  logic             w_crc_shift;

  assign w_crc_clear = (r_state == ST_IDLE) & w_edge & ~bus.rx_overflow;
  assign w_crc_shift = w_edge & ~bus.rx_overflow &
                       (r_state inside {ST_IDLE, ST_OPCODE, ST_PAYLOAD});

  crc5_serial u_crc5 (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_crc_clear),
    .shift   (w_crc_shift),
    .din     (bus.bitin),
    .residue (w_residue)
  );

  assign w_crc_bad = (r_type == CMD_QUERY) && (w_residue != '0);
`else
  assign w_crc_bad = 1'b0;
`endif

  // Next state, datapath updates and error pulse
  always_comb begin
    w_next_state = r_state;
    w_data_nxt   = r_data;
    w_cnt_nxt    = r_cnt;
    w_type_nxt   = r_type;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge && !bus.rx_overflow) begin
          w_data_nxt   = DATA_W'(bus.bitin);
          w_cnt_nxt    = CNT_W'(1);
          w_next_state = ST_OPCODE;
        end
      end
      ST_OPCODE: begin
        if (bus.rx_overflow) begin
          w_next_state = ST_IDLE;
          w_err        = 1'b1;
        end else if (w_edge) begin
          w_data_nxt = w_shift_data;
          w_cnt_nxt  = w_shift_cnt;
          case (w_shift_cnt)
            CNT_W'(2): begin
              if (w_shift_data[1:0] == OP_QUERYREP) begin
                w_type_nxt = CMD_QUERYREP; w_next_state = ST_PAYLOAD;
              end else if (w_shift_data[1:0] == OP_ACK) begin
                w_type_nxt = CMD_ACK;      w_next_state = ST_PAYLOAD;
              end
            end
            CNT_W'(4): begin
              // 11xx prefixes still need eight bits to resolve
              if (w_shift_data[3:2] == 2'b10) begin
                if (w_shift_data[3:0] == OP_QUERY) begin
                  w_type_nxt = CMD_QUERY;    w_next_state = ST_PAYLOAD;
                end else if (w_shift_data[3:0] == OP_QUERYADJ) begin
                  w_type_nxt = CMD_QUERYADJ; w_next_state = ST_PAYLOAD;
                end else begin
                  w_next_state = ST_DISCARD; w_err = 1'b1;
                end
              end
            end
            CNT_W'(8): begin
              if (w_shift_data[7:0] == OP_NAK) begin
                w_type_nxt = CMD_NAK;   w_next_state = ST_WAIT_END;
              end else if (w_shift_data[7:0] == OP_REQRN) begin
                w_type_nxt = CMD_REQRN; w_next_state = ST_PAYLOAD;
              end else if (w_shift_data[7:0] == OP_READ) begin
                w_type_nxt = CMD_READ;  w_next_state = ST_PAYLOAD;
              end else begin
                w_next_state = ST_DISCARD; w_err = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_PAYLOAD: begin
        if (bus.rx_overflow) begin
          w_next_state = ST_IDLE;
          w_err        = 1'b1;
        end else if (w_edge) begin
          w_data_nxt = w_shift_data;
          w_cnt_nxt  = w_shift_cnt;
          if (w_shift_cnt == cmd_length(r_type)) w_next_state = ST_WAIT_END;
        end
      end
      ST_WAIT_END: begin
        if (bus.rx_overflow) begin
          if (w_crc_bad) begin
            w_next_state = ST_IDLE; w_err = 1'b1;
          end else begin
            w_next_state = ST_DONE;
          end
        end else if (w_edge) begin
          w_next_state = ST_DISCARD;
          w_err        = 1'b1;
        end
      end
      ST_DONE: begin
        if (w_edge)      w_err        = 1'b1;
        if (bus.cmd_ack) w_next_state = ST_IDLE;
      end
      ST_DISCARD: begin
        if (bus.rx_overflow) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_bitclk_d <= 1'b0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_type     <= CMD_QUERYREP;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_bitclk_d <= bus.bitclk;
      r_data     <= w_data_nxt;
      r_cnt      <= w_cnt_nxt;
      r_type     <= w_type_nxt;
      r_valid    <= (w_next_state == ST_DONE);
      r_err      <= w_err;
      r_busy     <= (w_next_state != ST_IDLE);
    end
  end

  assign bus.cmd_valid = r_valid;
  assign bus.cmd_type  = r_type;
  assign bus.cmd_data  = r_data;
  assign bus.cmd_len   = r_cnt;
  assign bus.cmd_err   = r_err;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Testbench for rx_cmd_sequencer: directed frames, a frame-level reference
// model (opcode table lookup on the collected bit list) compared every cycle,
// and literal expectations for the named scenarios.
module tb_rx_cmd_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   err_seen = 0;

  rx_cmd_sequencer_if bus();

  rx_cmd_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Command table indexed by type code
  int T_OPLEN [7] = '{2, 2, 4, 4, 8, 8, 8};
  int T_OP    [7] = '{0, 1, 8, 9, 'hC0, 'hC1, 'hC2};
  int T_LEN   [7] = '{4, 18, 22, 9, 8, 40, 58};

  typedef enum {P_IDLE, P_COLLECT, P_FULL, P_HELD, P_JUNK} phase_e;
  phase_e phase = P_IDLE;
  bit     m_bits[$];
  bit     m_prev = 1'b0;
  int     m_type = 0;
  bit     exp_err = 1'b0;

  function automatic logic [63:0] prefix(input int k);
    logic [63:0] v = '0;
    for (int i = 0; i < k; i++) v = {v[62:0], m_bits[i]};
    return v;
  endfunction

  // -1 bad opcode, 0 incomplete, 1 complete frame
  function automatic int classify(output int typ);
    int n = m_bits.size();
    int oplen;
    int idx = -1;
    typ = 0;
    if (m_bits[0] == 1'b0) oplen = 2;
    else if (n < 2) return 0;
    else oplen = m_bits[1] ? 8 : 4;
    if (n < oplen) return 0;
    for (int i = 0; i < 7; i++)
      if (T_OPLEN[i] == oplen && 64'(T_OP[i]) == prefix(oplen)) idx = i;
    if (idx < 0) return -1;
    typ = idx;
    return (n == T_LEN[idx]) ? 1 : 0;
  endfunction

  function automatic bit crc_bad();
`ifdef RX_CMD_CRC5_EN
    logic [4:0] c = 5'b01001;
    bit fb;
    if (m_type != 2) return 1'b0;
    foreach (m_bits[i]) begin
      fb = m_bits[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
    end
    return c != 5'b00000;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    phase   = P_IDLE;
    m_prev  = 1'b0;
    exp_err = 1'b0;
    m_bits.delete();
  endtask

  task automatic model_step();
    bit b_edge;
    int r, t;
    b_edge  = bus.bitclk && !m_prev;
    m_prev  = bus.bitclk;
    exp_err = 1'b0;
    case (phase)
      P_IDLE: if (b_edge && !bus.rx_overflow) begin
        m_bits.delete();
        m_bits.push_back(bus.bitin);
        phase = P_COLLECT;
      end
      P_COLLECT: begin
        if (bus.rx_overflow) begin
          phase = P_IDLE; exp_err = 1'b1;
        end else if (b_edge) begin
          m_bits.push_back(bus.bitin);
          r = classify(t);
          if (r < 0) begin phase = P_JUNK; exp_err = 1'b1; end
          else if (r > 0) begin phase = P_FULL; m_type = t; end
        end
      end
      P_FULL: begin
        if (bus.rx_overflow) begin
          if (crc_bad()) begin phase = P_IDLE; exp_err = 1'b1; end
          else phase = P_HELD;
        end else if (b_edge) begin
          phase = P_JUNK; exp_err = 1'b1;
        end
      end
      P_HELD: begin
        if (b_edge) exp_err = 1'b1;
        if (bus.cmd_ack) phase = P_IDLE;
      end
      P_JUNK: if (bus.rx_overflow) phase = P_IDLE;
      default: phase = P_IDLE;
    endcase
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    cmp("cmd_valid", 64'(bus.cmd_valid), 64'(phase == P_HELD));
    cmp("cmd_err",   64'(bus.cmd_err),   64'(exp_err));
    cmp("busy",      64'(bus.busy),      64'(phase != P_IDLE));
    if (phase == P_HELD) begin
      cmp("cmd_type", 64'(bus.cmd_type), 64'(m_type));
      cmp("cmd_len",  64'(bus.cmd_len),  64'(m_bits.size()));
      cmp("cmd_data", bus.cmd_data,      prefix(m_bits.size()));
    end
  endtask

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
      if (bus.cmd_err === 1'b1) err_seen++;
      check_outputs();
    end
  end

  task automatic send_bit(input bit b);
    @(negedge clk); bus.bitin = b; bus.bitclk = 1'b1;
    @(negedge clk); bus.bitclk = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic overflow();
    @(negedge clk); bus.rx_overflow = 1'b1;
    @(negedge clk); bus.rx_overflow = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); bus.cmd_ack = 1'b1;
    @(negedge clk); bus.cmd_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (bus.cmd_valid !== 1'b1 && k < budget) begin
      @(negedge clk); k++;
    end
    cmp("wait_valid", 64'(bus.cmd_valid), 64'(1));
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_valid"}, 64'(bus.cmd_valid), 64'(0));
    cmp({tag, "_err"},   64'(bus.cmd_err),   64'(0));
    cmp({tag, "_busy"},  64'(bus.busy),      64'(0));
    cmp({tag, "_type"},  64'(bus.cmd_type),  64'(0));
    cmp({tag, "_data"},  bus.cmd_data,       64'(0));
    cmp({tag, "_len"},   64'(bus.cmd_len),   64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0;
    reset = 1'b1;
    bus.bitin = 1'b0; bus.bitclk = 1'b0; bus.rx_overflow = 1'b0; bus.cmd_ack = 1'b0;
    idle(3);
    check_all_zero("reset");
    reset = 1'b0;
    idle(2);

    // QueryRep 0011
    send_bits(64'h3, 4);
    overflow();
    wait_valid(4);
    cmp("qrep_type", 64'(bus.cmd_type), 64'(0));
    cmp("qrep_len",  64'(bus.cmd_len),  64'(4));
    cmp("qrep_data", bus.cmd_data,      64'h3);
    do_ack();
    cmp("qrep_valid_after_ack", 64'(bus.cmd_valid), 64'(0));
    idle(2);

    // ACK 01 + 0xBEEF, acknowledged late
    send_bits(64'h1, 2);
    send_bits(64'hBEEF, 16);
    overflow();
    wait_valid(4);
    idle(3);
    cmp("ack_type", 64'(bus.cmd_type), 64'(1));
    cmp("ack_len",  64'(bus.cmd_len),  64'(18));
    cmp("ack_data", bus.cmd_data,      64'h1BEEF);
    do_ack();
    cmp("ack_valid_after", 64'(bus.cmd_valid), 64'(0));
    cmp("ack_busy_after",  64'(bus.busy),      64'(0));
    idle(2);

    // Bad opcode 1011
    e0 = err_seen;
    send_bits(64'hB, 4);
    idle(2);
    cmp("badop_busy", 64'(bus.busy), 64'(1));
    cmp("badop_errs", 64'(err_seen - e0), 64'(1));
    overflow();
    idle(1);
    cmp("badop_busy_end", 64'(bus.busy), 64'(0));
    cmp("badop_errs_end", 64'(err_seen - e0), 64'(1));
    cmp("badop_valid",    64'(bus.cmd_valid), 64'(0));

    // REQRN cut short at 20 bits
    send_bits(64'hC1, 8);
    send_bits(64'hABC, 12);
    e0 = err_seen;
    overflow();
    idle(1);
    cmp("reqrn_short_errs", 64'(err_seen - e0), 64'(1));
    cmp("reqrn_short_busy", 64'(bus.busy), 64'(0));

    // ACK with one extra bit
    send_bits(64'h1, 2);
    send_bits(64'h1234, 16);
    e0 = err_seen;
    send_bit(1'b1);
    cmp("ack19_errs", 64'(err_seen - e0), 64'(1));
    cmp("ack19_busy", 64'(bus.busy), 64'(1));
    overflow();
    idle(1);
    cmp("ack19_errs_end", 64'(err_seen - e0), 64'(1));
    cmp("ack19_busy_end", 64'(bus.busy), 64'(0));

    // Query 1000 + 13 zero bits + wrong CRC 00000
    send_bits(64'h8, 4);
    send_bits(64'h0, 13);
    send_bits(64'h0, 5);
    e0 = err_seen;
    overflow();
`ifdef RX_CMD_CRC5_EN
    idle(1);
    cmp("query_crc_errs",  64'(err_seen - e0), 64'(1));
    cmp("query_crc_valid", 64'(bus.cmd_valid), 64'(0));
`else
    wait_valid(4);
    cmp("query_type", 64'(bus.cmd_type), 64'(2));
    cmp("query_len",  64'(bus.cmd_len),  64'(22));
    cmp("query_data", bus.cmd_data,      64'h200000);
    do_ack();
`endif
    idle(2);

    // READ interrupted by reset after 30 bits
    send_bits(64'hC2, 8);
    send_bits(64'h2AAAAA, 22);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    idle(2);
    reset = 1'b0;
    idle(2);

    // NAK after reset, then a stray bit while held
    send_bits(64'hC0, 8);
    overflow();
    wait_valid(4);
    cmp("nak_type", 64'(bus.cmd_type), 64'(4));
    cmp("nak_len",  64'(bus.cmd_len),  64'(8));
    cmp("nak_data", bus.cmd_data,      64'hC0);
    e0 = err_seen;
    send_bit(1'b1);
    cmp("done_bit_errs",  64'(err_seen - e0), 64'(1));
    cmp("done_bit_data",  bus.cmd_data,       64'hC0);
    cmp("done_bit_valid", 64'(bus.cmd_valid), 64'(1));
    do_ack();
    idle(2);

    // Overflow and bit edge together in payload: overflow wins
    send_bits(64'h0, 2);
    e0 = err_seen;
    @(negedge clk); bus.bitin = 1'b1; bus.bitclk = 1'b1; bus.rx_overflow = 1'b1;
    @(negedge clk); bus.bitclk = 1'b0; bus.rx_overflow = 1'b0;
    cmp("ovf_edge_errs", 64'(err_seen - e0), 64'(1));
    cmp("ovf_edge_busy", 64'(bus.busy), 64'(0));

    // Stray ack while idle
    do_ack();
    idle(2);
    cmp("stray_ack_busy", 64'(bus.busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
